// File: rtl/atm_cash_dispense_ctrl.sv
// -----------------------------------------------------------------------------
// atm_cash_dispense_ctrl
// Note dispenser sequencer for an already-approved withdrawal. It plans a
// greedy note breakdown over three cassettes, checks stock, and then hands the
// notes to the dispenser mechanism one at a time.
//
// Ports
//   Clock, Reset                  rising-edge clock, async active-high reset
//   Dispense_Req/Dispense_Amount  start request + amount (sampled in IDLE)
//   Abort                         cancel the current transaction
//   Refill_En/Sel/Count           load a cassette stock value (IDLE only)
//   Feed_Valid/Feed_Sel/Feed_Ready note handshake to the mechanism
//   Dispense_Busy/Done/Error      status; Done and Error are 1-cycle pulses
//   Error_Code                    00 abort, 01 bad amount, 10 stock short,
//                                 11 too many notes; held until next request
//   Cassette0..2_Count            live cassette stock
//   Notes_Dispensed               notes delivered in current/last transaction
//   dbg_state                     current FSM state (IDLE encodes as 0)
//
// Feed handshake: a note transfers on a rising edge where Feed_Valid and
// Feed_Ready are both high. Once Feed_Valid rises, Feed_Valid and Feed_Sel
// stay stable until that transfer; Feed_Valid then drops for at least one
// cycle before the next note is offered.
// -----------------------------------------------------------------------------
module atm_cash_dispense_ctrl #(
   parameter int AMT_W     = 32,
   parameter int NOTE_W    = 8,
   parameter int DENOM0    = 200,
   parameter int DENOM1    = 100,
   parameter int DENOM2    = 50,
   parameter int MAX_NOTES = 40
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Dispense_Req,
   input  logic [AMT_W-1:0]  Dispense_Amount,
   input  logic              Abort,
   input  logic              Refill_En,
   input  logic [1:0]        Refill_Sel,
   input  logic [NOTE_W-1:0] Refill_Count,
   input  logic              Feed_Ready,
   output logic              Feed_Valid,
   output logic [1:0]        Feed_Sel,
   output logic              Dispense_Busy,
   output logic              Dispense_Done,
   output logic              Dispense_Error,
   output logic [1:0]        Error_Code,
   output logic [NOTE_W-1:0] Cassette0_Count,
   output logic [NOTE_W-1:0] Cassette1_Count,
   output logic [NOTE_W-1:0] Cassette2_Count,
   output logic [7:0]        Notes_Dispensed,
   output logic [2:0]        dbg_state
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_CHECK    = 3'd1;
   localparam logic [2:0] S_PLAN     = 3'd2;
   localparam logic [2:0] S_DISPENSE = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;
   localparam logic [2:0] S_ERR      = 3'd5;

   localparam logic [1:0] E_ABORT = 2'b00;
   localparam logic [1:0] E_AMT   = 2'b01;
   localparam logic [1:0] E_STOCK = 2'b10;
   localparam logic [1:0] E_MAX   = 2'b11;

   localparam int SUM_W = NOTE_W + 2;

   logic [2:0]        state_q, state_d;
   logic [AMT_W-1:0]  rem_q, rem_d;
   logic [NOTE_W-1:0] plan0_q, plan0_d, plan1_q, plan1_d, plan2_q, plan2_d;
   logic [NOTE_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [7:0]        notes_q, notes_d;
   logic [1:0]        err_code_q, err_code_d;
   logic              feed_valid_q, feed_valid_d;
   logic [1:0]        feed_sel_q, feed_sel_d;
   logic              abort_pend_q, abort_pend_d;
   logic [SUM_W-1:0]  plan_total;

   assign plan_total = SUM_W'(plan0_q) + SUM_W'(plan1_q) + SUM_W'(plan2_q);

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      plan0_d      = plan0_q;
      plan1_d      = plan1_q;
      plan2_d      = plan2_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;
      cnt2_d       = cnt2_q;
      notes_d      = notes_q;
      err_code_d   = err_code_q;
      feed_valid_d = feed_valid_q;
      feed_sel_d   = feed_sel_q;
      abort_pend_d = abort_pend_q;

      case (state_q)
         S_IDLE: begin
            if (Refill_En) begin
               case (Refill_Sel)
                  2'd0:    cnt0_d = Refill_Count;
                  2'd1:    cnt1_d = Refill_Count;
                  2'd2:    cnt2_d = Refill_Count;
                  default: ;
               endcase
            end
            if (Dispense_Req) begin
               rem_d        = Dispense_Amount;
               plan0_d      = '0;
               plan1_d      = '0;
               plan2_d      = '0;
               notes_d      = '0;
               err_code_d   = 2'b00;
               abort_pend_d = 1'b0;
               state_d      = S_CHECK;
            end
         end

         S_CHECK: begin
            if (Abort) begin
               err_code_d = E_ABORT;
               state_d    = S_ERR;
            end else if (rem_q == '0) begin
               err_code_d = E_AMT;
               state_d    = S_ERR;
            end else begin
               state_d = S_PLAN;
            end
         end

         // One note planned per cycle, largest denomination first.
         S_PLAN: begin
            if (Abort) begin
               err_code_d = E_ABORT;
               state_d    = S_ERR;
            end else if (rem_q == '0) begin
               state_d = S_DISPENSE;
            end else if (plan_total >= SUM_W'(MAX_NOTES)) begin
               err_code_d = E_MAX;
               state_d    = S_ERR;
            end else if (rem_q >= AMT_W'(DENOM0) && plan0_q < cnt0_q) begin
               plan0_d = plan0_q + 1'b1;
               rem_d   = rem_q - AMT_W'(DENOM0);
            end else if (rem_q >= AMT_W'(DENOM1) && plan1_q < cnt1_q) begin
               plan1_d = plan1_q + 1'b1;
               rem_d   = rem_q - AMT_W'(DENOM1);
            end else if (rem_q >= AMT_W'(DENOM2) && plan2_q < cnt2_q) begin
               plan2_d = plan2_q + 1'b1;
               rem_d   = rem_q - AMT_W'(DENOM2);
            end else if (rem_q < AMT_W'(DENOM2)) begin
               err_code_d = E_AMT;
               state_d    = S_ERR;
            end else begin
               err_code_d = E_STOCK;
               state_d    = S_ERR;
            end
         end

         S_DISPENSE: begin
            // An abort seen while a note is in flight waits for its transfer.
            abort_pend_d = abort_pend_q | Abort;
            if (feed_valid_q) begin
               if (Feed_Ready) begin
                  feed_valid_d = 1'b0;
                  notes_d      = notes_q + 8'd1;
                  case (feed_sel_q)
                     2'd0: begin
                        cnt0_d  = cnt0_q - 1'b1;
                        plan0_d = plan0_q - 1'b1;
                     end
                     2'd1: begin
                        cnt1_d  = cnt1_q - 1'b1;
                        plan1_d = plan1_q - 1'b1;
                     end
                     default: begin
                        cnt2_d  = cnt2_q - 1'b1;
                        plan2_d = plan2_q - 1'b1;
                     end
                  endcase
               end
            end else if (abort_pend_q || Abort) begin
               abort_pend_d = 1'b0;
               err_code_d   = E_ABORT;
               state_d      = S_ERR;
            end else if (plan0_q == '0 && plan1_q == '0 && plan2_q == '0) begin
               state_d = S_DONE;
            end else begin
               feed_valid_d = 1'b1;
               if (plan0_q != '0)      feed_sel_d = 2'd0;
               else if (plan1_q != '0) feed_sel_d = 2'd1;
               else                    feed_sel_d = 2'd2;
            end
         end

         S_DONE: state_d = S_IDLE;

         S_ERR: begin
            feed_valid_d = 1'b0;
            abort_pend_d = 1'b0;
            state_d      = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         rem_q        <= '0;
         plan0_q      <= '0;
         plan1_q      <= '0;
         plan2_q      <= '0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
         cnt2_q       <= '0;
         notes_q      <= '0;
         err_code_q   <= '0;
         feed_valid_q <= 1'b0;
         feed_sel_q   <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         plan0_q      <= plan0_d;
         plan1_q      <= plan1_d;
         plan2_q      <= plan2_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
         cnt2_q       <= cnt2_d;
         notes_q      <= notes_d;
         err_code_q   <= err_code_d;
         feed_valid_q <= feed_valid_d;
         feed_sel_q   <= feed_sel_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   assign Feed_Valid      = feed_valid_q;
   assign Feed_Sel        = feed_sel_q;
   assign Dispense_Busy   = (state_q != S_IDLE);
   assign Dispense_Done   = (state_q == S_DONE);
   assign Dispense_Error  = (state_q == S_ERR);
   assign Error_Code      = err_code_q;
   assign Cassette0_Count = cnt0_q;
   assign Cassette1_Count = cnt1_q;
   assign Cassette2_Count = cnt2_q;
   assign Notes_Dispensed = notes_q;
   assign dbg_state       = state_q;

endmodule
